morra_scoreboard: RTL and testbench
===================================

MORRA_SCOREBOARD -- requirements
Module: morra_scoreboard

Interface
REQ-001 SHALL have parameter: CNT_W, 5, width of round tally counters (saturating at 2^CNT_W-1).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: RST_N  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: START  input  1  new-game request, same signal that drives the game FSM.
REQ-005 SHALL have port: ROUND  input  2  per-cycle round result from game FSM (00 void, 01 P1, 10 P2, 11 draw).
REQ-006 SHALL have port: GAME  input  2  game result from game FSM (00 running, 01/10/11 final outcome code).
REQ-007 SHALL have port: WINS_P1, WINS_P2, DRAWS  output  CNT_W each  round tallies for the current game.
REQ-008 SHALL have port: VOIDS  output  CNT_W  count of void rounds in the current game.
REQ-009 SHALL have port: GAMES_P1, GAMES_P2, GAMES_TIE  output  4 each  game tallies across games since reset.
REQ-010 SHALL have port: WINNER  output  2  latched GAME code of the last finished game.
REQ-011 SHALL have port: GAME_DONE  output  1  one-cycle pulse when a game finishes.
REQ-012 SHALL have port: BUSY  output  1  high while in PLAYING.
REQ-013 SHALL have port: HISTORY  output  16  last 8 non-void round codes, newest in [1:0].

Function
REQ-014 SHALL implement FSM states IDLE, PLAYING, DONE; all outputs registered.
REQ-015 SHALL, in any state with START=1, clear WINS_P1/WINS_P2/DRAWS/VOIDS/HISTORY and enter PLAYING next cycle; game tallies and WINNER are kept.
REQ-016 SHALL, in PLAYING with START=0, sample ROUND each cycle: 01 -> WINS_P1+1, 10 -> WINS_P2+1, 11 -> DRAWS+1, 00 -> VOIDS+1; update visible one cycle after sample.
REQ-017 SHALL saturate every round tally at 2^CNT_W-1 and every game tally at 15; no wrap.
REQ-018 SHALL, in PLAYING with START=0 and GAME!=00, count that cycle's ROUND first, latch WINNER=GAME, increment the matching game tally (01 P1, 10 P2, 11 tie), pulse GAME_DONE for exactly one cycle, enter DONE.
REQ-019 SHALL, in DONE, hold all tallies and WINNER and ignore ROUND/GAME until START=1.
REQ-020 SHALL, in IDLE, ignore ROUND and GAME.
REQ-021 SHALL give START priority over GAME in the same cycle: no GAME_DONE, no game-tally update.
REQ-022 SHALL assert BUSY exactly when state is PLAYING.

Reset
REQ-023 SHALL, on RST_N=0 (asynchronous, any state, mid-game included), enter IDLE and drive all counters, WINNER, HISTORY, GAME_DONE, BUSY to 0.
REQ-024 SHALL leave reset synchronously on the first clk edge with RST_N=1.

Configuration
REQ-025 SHALL, with macro MORRA_HISTORY_EN defined, shift each non-void sampled ROUND code into HISTORY (left shift by 2, newest in [1:0], oldest dropped after 8).
REQ-026 SHALL, without MORRA_HISTORY_EN, tie HISTORY to 16'h0000 and synthesise no history storage.

Verification
REQ-027 SHALL cover: reset, START pulse, ROUND sequence 01,01,10,11,00 -> WINS_P1=2, WINS_P2=1, DRAWS=1, VOIDS=1, BUSY=1.
REQ-028 SHALL cover: GAME=10 with ROUND=10 in the same cycle -> WINS_P2 incremented, WINNER=10, GAMES_P2=1, GAME_DONE high exactly one cycle, BUSY=0 after.
REQ-029 SHALL cover: 40 consecutive ROUND=01 with CNT_W=5 -> WINS_P1 saturates at 31.
REQ-030 SHALL cover: START=1 and GAME=01 in the same cycle -> GAMES_P1 unchanged, no GAME_DONE, round tallies cleared.
REQ-031 SHALL cover: RST_N low mid-game with WINS_P1=3 and GAMES_TIE=2 -> all outputs 0 immediately, before the next clk edge.
REQ-032 SHALL cover, with MORRA_HISTORY_EN: ROUND 01,00,10,11 -> HISTORY=16'h001B; without the macro -> HISTORY=16'h0000.

Source files
------------

// File: rtl/morra_scoreboard.sv
// ============================================================================
// Module      : morra_scoreboard
// Description : Round/game tally keeper for a Morra game FSM. Optional round
//               history register enabled by defining MORRA_HISTORY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morra_scoreboard #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       ROUND,
    input  logic [1:0]       GAME,
    output logic [CNT_W-1:0] WINS_P1,
    output logic [CNT_W-1:0] WINS_P2,
    output logic [CNT_W-1:0] DRAWS,
    output logic [CNT_W-1:0] VOIDS,
    output logic [3:0]       GAMES_P1,
    output logic [3:0]       GAMES_P2,
    output logic [3:0]       GAMES_TIE,
    output logic [1:0]       WINNER,
    output logic             GAME_DONE,
    output logic             BUSY,
    output logic [15:0]      HISTORY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_rnd_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       c_game_one = 4'd1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wins_p1_q, wins_p1_d;
    logic [CNT_W-1:0] wins_p2_q, wins_p2_d;
    logic [CNT_W-1:0] draws_q, draws_d;
    logic [CNT_W-1:0] voids_q, voids_d;
    logic [3:0]       games_p1_q, games_p1_d;
    logic [3:0]       games_p2_q, games_p2_d;
    logic [3:0]       games_tie_q, games_tie_d;
    logic [1:0]       winner_q, winner_d;
    logic             game_done_q, game_done_d;
    logic             w_sample;

    function automatic logic [CNT_W-1:0] sat_rnd(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + c_rnd_one;
    endfunction

    function automatic logic [3:0] sat_game(input logic [3:0] v);
        return (v == 4'hF) ? v : v + c_game_one;
    endfunction

    // A round is only taken while playing and not being restarted.
    assign w_sample = (state_q == PLAYING) && !START;

    always_comb begin
        state_d     = state_q;
        wins_p1_d   = wins_p1_q;
        wins_p2_d   = wins_p2_q;
        draws_d     = draws_q;
        voids_d     = voids_q;
        games_p1_d  = games_p1_q;
        games_p2_d  = games_p2_q;
        games_tie_d = games_tie_q;
        winner_d    = winner_q;
        game_done_d = 1'b0;

        if (START) begin
            wins_p1_d = '0;
            wins_p2_d = '0;
            draws_d   = '0;
            voids_d   = '0;
            state_d   = PLAYING;
        end else if (w_sample) begin
            case (ROUND)
                2'b01:   wins_p1_d = sat_rnd(wins_p1_q);
                2'b10:   wins_p2_d = sat_rnd(wins_p2_q);
                2'b11:   draws_d   = sat_rnd(draws_q);
                default: voids_d   = sat_rnd(voids_q);
            endcase
            if (GAME != 2'b00) begin
                winner_d    = GAME;
                game_done_d = 1'b1;
                state_d     = DONE;
                case (GAME)
                    2'b01:   games_p1_d  = sat_game(games_p1_q);
                    2'b10:   games_p2_d  = sat_game(games_p2_q);
                    default: games_tie_d = sat_game(games_tie_q);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            wins_p1_q   <= '0;
            wins_p2_q   <= '0;
            draws_q     <= '0;
            voids_q     <= '0;
            games_p1_q  <= '0;
            games_p2_q  <= '0;
            games_tie_q <= '0;
            winner_q    <= '0;
            game_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wins_p1_q   <= wins_p1_d;
            wins_p2_q   <= wins_p2_d;
            draws_q     <= draws_d;
            voids_q     <= voids_d;
            games_p1_q  <= games_p1_d;
            games_p2_q  <= games_p2_d;
            games_tie_q <= games_tie_d;
            winner_q    <= winner_d;
            game_done_q <= game_done_d;
        end
    end

`ifdef MORRA_HISTORY_EN
    logic [15:0] history_q, history_d;

    always_comb begin
        history_d = history_q;
        if (START) begin
            history_d = '0;
        end else if (w_sample && (ROUND != 2'b00)) begin
            history_d = {history_q[13:0], ROUND};
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            history_q <= '0;
        end else begin
            history_q <= history_d;
        end
    end

    assign HISTORY = history_q;
`else
    assign HISTORY = 16'h0000;
`endif

    assign WINS_P1   = wins_p1_q;
    assign WINS_P2   = wins_p2_q;
    assign DRAWS     = draws_q;
    assign VOIDS     = voids_q;
    assign GAMES_P1  = games_p1_q;
    assign GAMES_P2  = games_p2_q;
    assign GAMES_TIE = games_tie_q;
    assign WINNER    = winner_q;
    assign GAME_DONE = game_done_q;
    assign BUSY      = (state_q == PLAYING);

endmodule

`default_nettype wire

// File: tb/tb_morra_scoreboard.sv
// ============================================================================
// Module      : tb_morra_scoreboard
// Description : Directed self-checking bench for morra_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morra_scoreboard;

    localparam int CNT_W = 5;

    logic             clk;
    logic             RST_N;
    logic             START;
    logic [1:0]       ROUND;
    logic [1:0]       GAME;
    logic [CNT_W-1:0] WINS_P1, WINS_P2, DRAWS, VOIDS;
    logic [3:0]       GAMES_P1, GAMES_P2, GAMES_TIE;
    logic [1:0]       WINNER;
    logic             GAME_DONE, BUSY;
    logic [15:0]      HISTORY;

    int n_checks = 0;
    int n_fails  = 0;

    morra_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .RST_N     (RST_N),
        .START     (START),
        .ROUND     (ROUND),
        .GAME      (GAME),
        .WINS_P1   (WINS_P1),
        .WINS_P2   (WINS_P2),
        .DRAWS     (DRAWS),
        .VOIDS     (VOIDS),
        .GAMES_P1  (GAMES_P1),
        .GAMES_P2  (GAMES_P2),
        .GAMES_TIE (GAMES_TIE),
        .WINNER    (WINNER),
        .GAME_DONE (GAME_DONE),
        .BUSY      (BUSY),
        .HISTORY   (HISTORY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge: apply inputs, return at the next falling edge.
    task automatic step(input logic s, input logic [1:0] r, input logic [1:0] g);
        START = s;
        ROUND = r;
        GAME  = g;
        @(negedge clk);
        START = 1'b0;
        ROUND = 2'b00;
        GAME  = 2'b00;
    endtask

    logic [15:0] exp_hist;

    initial begin
        RST_N = 1'b0;
        START = 1'b0;
        ROUND = 2'b00;
        GAME  = 2'b00;
        repeat (2) @(negedge clk);

        check("rst_wins_p1", WINS_P1, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", GAME_DONE, 0);
        check("rst_winner", WINNER, 0);
        check("rst_hist", HISTORY, 0);
        RST_N = 1'b1;
        @(negedge clk);

        // IDLE ignores ROUND/GAME
        step(1'b0, 2'b01, 2'b01);
        check("idle_wins_p1", WINS_P1, 0);
        check("idle_games_p1", GAMES_P1, 0);
        check("idle_done", GAME_DONE, 0);
        check("idle_busy", BUSY, 0);

        step(1'b1, 2'b00, 2'b00);
        check("start_busy", BUSY, 1);

        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b10, 2'b00);
        step(1'b0, 2'b11, 2'b00);
        step(1'b0, 2'b00, 2'b00);
        check("seq_wins_p1", WINS_P1, 2);
        check("seq_wins_p2", WINS_P2, 1);
        check("seq_draws", DRAWS, 1);
        check("seq_voids", VOIDS, 1);
        check("seq_busy", BUSY, 1);
`ifdef MORRA_HISTORY_EN
        exp_hist = 16'h005B;
`else
        exp_hist = 16'h0000;
`endif
        check("seq_hist", HISTORY, exp_hist);

        // Final round counted together with the game result
        step(1'b0, 2'b10, 2'b10);
        check("end_wins_p2", WINS_P2, 2);
        check("end_winner", WINNER, 2'b10);
        check("end_games_p2", GAMES_P2, 1);
        check("end_done", GAME_DONE, 1);
        check("end_busy", BUSY, 0);

        // DONE ignores ROUND/GAME
        step(1'b0, 2'b01, 2'b01);
        check("done_pulse_off", GAME_DONE, 0);
        check("done_wins_p1", WINS_P1, 2);
        check("done_games_p1", GAMES_P1, 0);
        check("done_winner", WINNER, 2'b10);
        check("done_busy", BUSY, 0);

        step(1'b1, 2'b00, 2'b00);
        check("restart_wins_p1", WINS_P1, 0);
        check("restart_wins_p2", WINS_P2, 0);
        check("restart_hist", HISTORY, 0);
        check("restart_games_p2", GAMES_P2, 1);

        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b00, 2'b00);
        step(1'b0, 2'b10, 2'b00);
        step(1'b0, 2'b11, 2'b00);
`ifdef MORRA_HISTORY_EN
        exp_hist = 16'h001B;
`else
        exp_hist = 16'h0000;
`endif
        check("hist_1b", HISTORY, exp_hist);
        check("hist_voids", VOIDS, 1);

        for (int i = 0; i < 40; i++) step(1'b0, 2'b01, 2'b00);
        check("sat_wins_p1", WINS_P1, 31);
        check("sat_busy", BUSY, 1);

        // START wins over GAME in the same cycle
        step(1'b1, 2'b01, 2'b01);
        check("prio_games_p1", GAMES_P1, 0);
        check("prio_done", GAME_DONE, 0);
        check("prio_wins_p1", WINS_P1, 0);
        check("prio_busy", BUSY, 1);
        check("prio_winner", WINNER, 2'b10);

        step(1'b0, 2'b00, 2'b11);
        check("tie1_games_tie", GAMES_TIE, 1);
        step(1'b1, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b11);
        check("tie2_games_tie", GAMES_TIE, 2);
        check("tie2_draws", DRAWS, 1);
        step(1'b1, 2'b00, 2'b00);
        repeat (3) step(1'b0, 2'b01, 2'b00);
        check("pre_rst_wins_p1", WINS_P1, 3);

        // Asynchronous reset observed before the next rising edge
        #2 RST_N = 1'b0;
        #1;
        check("arst_wins_p1", WINS_P1, 0);
        check("arst_games_tie", GAMES_TIE, 0);
        check("arst_games_p2", GAMES_P2, 0);
        check("arst_winner", WINNER, 0);
        check("arst_busy", BUSY, 0);
        check("arst_hist", HISTORY, 0);
        @(negedge clk);
        RST_N = 1'b1;
        @(negedge clk);

        // Game tally saturation at 15
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 2'b00, 2'b00);
            step(1'b0, 2'b00, 2'b01);
        end
        check("sat_games_p1", GAMES_P1, 15);
        check("sat_games_winner", WINNER, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        n_fails++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
